// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types, decision codes and saturating adder for the TC loop
package tc_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        HOLD  = 2'd3
    } tc_state_e;

    localparam logic signed [1:0] DEC_POS  = 2'sb01;
    localparam logic signed [1:0] DEC_ZERO = 2'sb00;
    localparam logic signed [1:0] DEC_NEG  = 2'sb11;

    localparam int SAT_W = 32;

    // One guard bit above SAT_W so the sum can never wrap before clamping.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input logic signed [SAT_W-1:0] lo,
        input logic signed [SAT_W-1:0] hi
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] lx;
        logic signed [SAT_W:0] hx;
        s  = a + b;
        lx = lo;
        hx = hi;
        if (s > hx)
            return hi;
        else if (s < lx)
            return lo;
        else
            return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/tc_mash1_dsm.sv
// rtl/tc_mash1_dsm.sv - first-order delta-sigma modulator for the LSB varactor
module tc_mash1_dsm #(
    parameter int FRAC_W = 16
) (
    input  logic              REFCLK,
    input  logic              NARST,
    input  logic              CE,
    input  logic [FRAC_W-1:0] FRAC,
    output logic              Q
);

    logic [FRAC_W-1:0] sum;
    logic [FRAC_W:0]   acc;

    assign acc = {1'b0, sum} + {1'b0, FRAC};

    always_ff @(posedge REFCLK or negedge NARST) begin
        if (!NARST) begin
            sum <= '0;
            Q   <= 1'b0;
        end else if (CE) begin
            sum <= acc[FRAC_W-1:0];
            Q   <= acc[FRAC_W];
        end
    end

endmodule

// File: rtl/tc_loop_ctrl.sv
// rtl/tc_loop_ctrl.sv - temperature-compensation loop: decision, PI filter, IIR, lock FSM, DSM
module tc_loop_ctrl
    import tc_pkg::*;
#(
    parameter int INT_W     = 4,
    parameter int FRAC_W    = 16,
    parameter int DIV_W     = 6,
    parameter int IIR_SHIFT = 8,
    parameter int LOCK_W    = 4
) (
    input  logic              REFCLK,
    input  logic              NARST,
    input  logic              TCEN,
    input  logic              TCFRZ,
    input  logic              COMP_HI,
    input  logic              COMP_LO,
    input  logic [3:0]        TCKPS,
    input  logic [3:0]        TCKIS,
    input  logic [DIV_W-1:0]  TCDIV,
    input  logic [INT_W-1:0]  TCLIM_HI,
    input  logic [INT_W-1:0]  TCLIM_LO,
    input  logic [LOCK_W-1:0] TCLOCKN,
    input  logic              DSM_CE,
    output logic [INT_W-1:0]  TCOTW_INT,
    output logic [FRAC_W-1:0] TCOTW_FRAC,
    output logic              TCOTWDSM,
    output logic              TCLOCK,
    output logic              TCSAT,
    output logic [1:0]        TCSTATE
);

    localparam int W = INT_W + FRAC_W;
    localparam logic signed [SAT_W-1:0] W_MAX = (32'sd1 <<< (W - 1)) - 32'sd1;
    localparam logic signed [SAT_W-1:0] W_MIN = -W_MAX - 32'sd1;

    tc_state_e          state;
    logic               hi_s1, hi_s2, lo_s1, lo_s2;
    logic [DIV_W-1:0]   div_cnt;
    logic               run, stb;
    logic signed [1:0]  dec, dec_now;
    logic signed [W-1:0] integ, dlf, y;
    logic [LOCK_W:0]    lock_cnt, lock_nxt;
    logic               lock_hit, miss;

    logic signed [W-1:0]     unit, inte, prop, lim_hi, lim_lo;
    logic signed [W-1:0]     integ_nxt, dlf_nxt, y_nxt;
    logic signed [SAT_W-1:0] integ_s, dlf_s;
    logic                    lim_ok, sat_nxt;
    logic                    unused_hi;

    assign TCSTATE = state;
    assign run     = (state == ACQ) || (state == TRACK);
    // Freeze and disable take effect in the same cycle, so no half-update leaks through.
    assign stb     = run && TCEN && !TCFRZ && (div_cnt >= TCDIV);

    always_comb begin
        dec_now = DEC_ZERO;
        if (hi_s2 && !lo_s2)
            dec_now = DEC_POS;
        else if (lo_s2 && !hi_s2)
            dec_now = DEC_NEG;
    end

    always_comb begin
        unit      = {{(W-2){dec[1]}}, dec} <<< FRAC_W;
        inte      = unit >>> TCKIS;
        prop      = unit >>> TCKPS;
        lim_hi    = {TCLIM_HI, {FRAC_W{1'b0}}};
        lim_lo    = {TCLIM_LO, {FRAC_W{1'b0}}};
        lim_ok    = $signed(TCLIM_LO) <= $signed(TCLIM_HI);
        integ_s   = sat_add(SAT_W'(integ), SAT_W'(inte), SAT_W'(lim_lo), SAT_W'(lim_hi));
        dlf_s     = sat_add(SAT_W'(integ), SAT_W'(prop), W_MIN, W_MAX);
        integ_nxt = lim_ok ? integ_s[W-1:0] : integ;
        dlf_nxt   = dlf_s[W-1:0];
        y_nxt     = y + (dlf >>> IIR_SHIFT) - (y >>> IIR_SHIFT);
        sat_nxt   = (integ_nxt == lim_lo) || (integ_nxt == lim_hi);
    end

    assign unused_hi = ^{integ_s[SAT_W-1:W], dlf_s[SAT_W-1:W]};

    always_ff @(posedge REFCLK or negedge NARST) begin
        if (!NARST) begin
            hi_s1      <= 1'b0;
            hi_s2      <= 1'b0;
            lo_s1      <= 1'b0;
            lo_s2      <= 1'b0;
            div_cnt    <= '0;
            dec        <= DEC_ZERO;
            integ      <= '0;
            dlf        <= '0;
            y          <= '0;
            TCOTW_INT  <= {1'b1, {(INT_W-1){1'b0}}};
            TCOTW_FRAC <= '0;
            TCSAT      <= 1'b0;
        end else begin
            hi_s1 <= COMP_HI;
            hi_s2 <= hi_s1;
            lo_s1 <= COMP_LO;
            lo_s2 <= lo_s1;
            if (stb)
                div_cnt <= '0;
            else if (run)
                div_cnt <= div_cnt + DIV_W'(1);
            else
                div_cnt <= '0;
            if (state == OFF)
                dec <= DEC_ZERO;
            else if (stb)
                dec <= dec_now;
            // Each stage consumes the previous stage's registered value: D -> INTEG/DLF -> Y -> OTW.
            if (stb) begin
                integ      <= integ_nxt;
                dlf        <= dlf_nxt;
                y          <= y_nxt;
                TCOTW_INT  <= {~y[W-1], y[W-2:FRAC_W]};
                TCOTW_FRAC <= y[FRAC_W-1:0];
                TCSAT      <= sat_nxt;
            end
        end
    end

    always_comb begin
        lock_nxt = (dec_now == DEC_ZERO) ? lock_cnt + (LOCK_W+1)'(1) : '0;
        lock_hit = lock_nxt >= {1'b0, TCLOCKN};
    end

    always_ff @(posedge REFCLK or negedge NARST) begin
        if (!NARST) begin
            state    <= OFF;
            TCLOCK   <= 1'b0;
            lock_cnt <= '0;
            miss     <= 1'b0;
        end else if (!TCEN) begin
            state    <= OFF;
            TCLOCK   <= 1'b0;
            lock_cnt <= '0;
            miss     <= 1'b0;
        end else if (TCFRZ && run) begin
            state <= HOLD;
        end else begin
            case (state)
                OFF: state <= ACQ;
                ACQ: if (stb) begin
                    lock_cnt <= lock_nxt;
                    if (lock_hit) begin
                        state  <= TRACK;
                        TCLOCK <= 1'b1;
                        miss   <= 1'b0;
                    end
                end
                TRACK: if (stb) begin
                    if (dec_now == DEC_ZERO) begin
                        miss <= 1'b0;
                    end else if (miss) begin
                        state    <= ACQ;
                        TCLOCK   <= 1'b0;
                        lock_cnt <= '0;
                        miss     <= 1'b0;
                    end else begin
                        miss <= 1'b1;
                    end
                end
                HOLD: if (!TCFRZ) begin
                    state    <= ACQ;
                    TCLOCK   <= 1'b0;
                    lock_cnt <= '0;
                    miss     <= 1'b0;
                end
                default: state <= OFF;
            endcase
        end
    end

    tc_mash1_dsm #(.FRAC_W(FRAC_W)) u_dsm (
        .REFCLK (REFCLK),
        .NARST  (NARST),
        .CE     (DSM_CE),
        .FRAC   (TCOTW_FRAC),
        .Q      (TCOTWDSM)
    );

endmodule

// File: tb/tb_tc_loop_ctrl.sv
// tb/tb_tc_loop_ctrl.sv - scoreboard bench for tc_loop_ctrl
module tb_tc_loop_ctrl;

    logic        REFCLK = 1'b0;
    logic        NARST = 1'b0;
    logic        TCEN = 1'b0, TCFRZ = 1'b0, COMP_HI = 1'b0, COMP_LO = 1'b0, DSM_CE = 1'b0;
    logic [3:0]  TCKPS = 4'd15, TCKIS = 4'd4;
    logic [5:0]  TCDIV = 6'd63;
    logic [3:0]  TCLIM_HI = 4'd6, TCLIM_LO = 4'd9;
    logic [3:0]  TCLOCKN = 4'd4;
    logic [3:0]  TCOTW_INT;
    logic [15:0] TCOTW_FRAC;
    logic        TCOTWDSM, TCLOCK, TCSAT;
    logic [1:0]  TCSTATE;

    tc_loop_ctrl dut (
        .REFCLK(REFCLK), .NARST(NARST), .TCEN(TCEN), .TCFRZ(TCFRZ),
        .COMP_HI(COMP_HI), .COMP_LO(COMP_LO), .TCKPS(TCKPS), .TCKIS(TCKIS),
        .TCDIV(TCDIV), .TCLIM_HI(TCLIM_HI), .TCLIM_LO(TCLIM_LO), .TCLOCKN(TCLOCKN),
        .DSM_CE(DSM_CE), .TCOTW_INT(TCOTW_INT), .TCOTW_FRAC(TCOTW_FRAC),
        .TCOTWDSM(TCOTWDSM), .TCLOCK(TCLOCK), .TCSAT(TCSAT), .TCSTATE(TCSTATE)
    );

    always #5 REFCLK = ~REFCLK;

    localparam int S_INT = 0, S_FRAC = 1, S_DSM = 2, S_LOCK = 3, S_SAT = 4, S_STATE = 5, S_DENS = 6;

    typedef struct {
        int    due;
        int    sel;
        int    val;
        int    tol;
        int    base;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ones_total = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t mon_e;
    int   mon_act, mon_diff;

    always @(posedge REFCLK) cyc <= cyc + 1;

    function automatic int observe(input int sel, input int base);
        case (sel)
            S_INT:   return int'(TCOTW_INT);
            S_FRAC:  return int'(TCOTW_FRAC);
            S_DSM:   return int'(TCOTWDSM);
            S_LOCK:  return int'(TCLOCK);
            S_SAT:   return int'(TCSAT);
            S_STATE: return int'(TCSTATE);
            default: return ones_total - base;
        endcase
    endfunction

    // Monitor: pops every expectation whose sample cycle has arrived.
    always @(negedge REFCLK) begin
        if (TCOTWDSM) ones_total = ones_total + 1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e    = sb.pop_front();
            mon_act  = observe(mon_e.sel, mon_e.base);
            mon_diff = mon_act - mon_e.val;
            if (mon_diff < 0) mon_diff = -mon_diff;
            checks = checks + 1;
            if (mon_diff > mon_e.tol) begin
                errors = errors + 1;
                $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d",
                         mon_e.name, mon_act, mon_e.val, mon_e.tol, cyc);
            end
        end
    end

    task automatic sb_push(input int dly, input int sel, input int val, input int tol, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.sel  = sel;
        e.val  = val;
        e.tol  = tol;
        e.base = ones_total;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge REFCLK);
        #2;
    endtask

    task automatic do_reset();
        NARST = 1'b0; TCEN = 1'b0; TCFRZ = 1'b0; COMP_HI = 1'b0; COMP_LO = 1'b0; DSM_CE = 1'b0;
        TCKPS = 4'd15; TCKIS = 4'd4; TCDIV = 6'd63; TCLIM_HI = 4'd6; TCLIM_LO = 4'd9; TCLOCKN = 4'd4;
        step(3);
        NARST = 1'b1;
        step(2);
    endtask

    initial begin
        // Reset state.
        do_reset();
        sb_push(0, S_INT,   8, 0, "reset_int");
        sb_push(0, S_FRAC,  0, 0, "reset_frac");
        sb_push(0, S_STATE, 0, 0, "reset_state");
        sb_push(0, S_LOCK,  0, 0, "reset_lock");
        sb_push(0, S_DSM,   0, 0, "reset_dsm");
        sb_push(0, S_SAT,   0, 0, "reset_sat");
        step(2);

        // Upward ramp to +6 at 1/16 per 64-cycle strobe (saturates near strobe 97).
        COMP_HI = 1'b1;
        step(5);
        TCEN = 1'b1;
        step(3000);
        sb_push(0, S_SAT,   0, 0, "up_sat_early");
        sb_push(0, S_STATE, 1, 0, "up_state_acq");
        step(4200);
        sb_push(0, S_SAT,   1, 0, "up_sat_late");
        TCDIV = 6'd0;
        step(4000);
        sb_push(0, S_INT,  14, 0, "up_int_settled");
        sb_push(0, S_SAT,   1, 0, "up_sat_hold");
        step(2);

        // Downward ramp to the -7 floor.
        do_reset();
        COMP_LO = 1'b1;
        step(5);
        TCEN = 1'b1;
        step(3000);
        sb_push(0, S_SAT, 0, 0, "dn_sat_early");
        step(5000);
        sb_push(0, S_SAT, 1, 0, "dn_sat_late");
        TCDIV = 6'd0;
        step(4000);
        sb_push(0, S_INT, 1, 1, "dn_int_settled");
        step(2);

        // Lock acquisition and loss, strobe every 4 cycles.
        do_reset();
        TCDIV = 6'd3;
        TCEN  = 1'b1;
        step(8);
        sb_push(0, S_LOCK,  0, 0, "lock_not_yet");
        sb_push(0, S_STATE, 1, 0, "lock_state_acq");
        step(16);
        sb_push(0, S_LOCK,  1, 0, "lock_acquired");
        sb_push(0, S_STATE, 2, 0, "lock_state_track");
        COMP_HI = 1'b1;
        step(4);
        COMP_HI = 1'b0;
        step(20);
        sb_push(0, S_LOCK,  1, 0, "lock_single_miss");
        sb_push(0, S_STATE, 2, 0, "lock_single_state");
        COMP_HI = 1'b1;
        step(20);
        sb_push(0, S_LOCK,  0, 0, "lock_lost");
        sb_push(0, S_STATE, 1, 0, "lock_lost_state");
        step(2);

        // Freeze before the first strobe, then release and disable.
        do_reset();
        TCDIV   = 6'd3;
        TCKIS   = 4'd0;
        COMP_HI = 1'b1;
        step(5);
        TCEN = 1'b1;
        step(2);
        TCFRZ = 1'b1;
        step(2);
        sb_push(0, S_STATE, 3, 0, "frz_state_hold");
        step(1000);
        sb_push(0, S_STATE, 3, 0, "frz_state_still");
        sb_push(0, S_SAT,   0, 0, "frz_sat");
        sb_push(0, S_INT,   8, 0, "frz_int");
        sb_push(0, S_FRAC,  0, 0, "frz_frac");
        TCFRZ = 1'b0;
        step(1);
        sb_push(0, S_STATE, 1, 0, "frz_release_acq");
        step(100);
        sb_push(0, S_SAT,   1, 0, "frz_ramp_resumed");
        TCEN = 1'b0;
        sb_push(1, S_STATE, 0, 0, "off_next_cycle");
        sb_push(1, S_LOCK,  0, 0, "off_lock");
        step(3);

        // Single-strobe impulse, IIR settling and DSM density.
        do_reset();
        TCDIV = 6'd0;
        TCKIS = 4'd2;
        TCKPS = 4'd15;
        TCEN  = 1'b1;
        step(10);
        COMP_HI = 1'b1;
        step(1);
        COMP_HI = 1'b0;
        step(3000);
        sb_push(0, S_FRAC, 16'h3FF8, 8, "iir_frac");
        sb_push(0, S_INT,  8, 0, "iir_int");
        DSM_CE = 1'b1;
        step(2);
        sb_push(4096, S_DENS, 1024, 41, "dsm_density");
        step(4100);

        for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
